// File: rtl/pcpu_mem_host.sv
// pcpu_mem_host
// Memory-side responder for the PCPU instruction and data buses. Holds a
// 2**ADDR_W x DATA_W instruction RAM and an equally sized data RAM. A
// byte-wide host port fills either RAM before the CPU runs. The host then
// requests a run, which gives one start pulse and keeps enable high until
// the host requests a stop.
//
// Ports
//   clock, reset           rising-edge clock, async active-low reset
//   host_valid/host_ready  host byte handshake (transfer on valid && ready)
//   host_data              host byte
//   host_sel               target RAM for a load (0 imem, 1 dmem), header byte 0
//   host_go / host_stop    run request (IDLE only) / stop request (RUN only)
//   busy                   high in any state other than IDLE
//   start / enable         PCPU start pulse / PCPU enable
//   i_addr / i_datain      instruction fetch, one-cycle registered read
//   d_addr / d_datain      data read, one-cycle registered read
//   d_dataout / d_we       CPU data write, honoured in START and RUN only
//
// Host load frame: ptr byte, count byte (0 = 256 words), then per word the
// high byte followed by the low byte.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a load header byte or a run request
// CNT   | waiting for the word-count byte
// HI    | waiting for the high byte of the next word
// LO    | waiting for the low byte; the word is written on acceptance
// START | one-cycle start pulse, enable high
// RUN   | CPU running, enable high, host bytes ignored
module pcpu_mem_host #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16   // word is assembled from two bytes, so 16 only
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [7:0]        host_data,
    input  logic              host_sel,
    input  logic              host_go,
    input  logic              host_stop,
    output logic              busy,
    output logic              start,
    output logic              enable,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_datain
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CNT   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_START = 3'd4,
        ST_RUN   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          hi_q, hi_d;
    logic                tgt_q, tgt_d;
    logic [DATA_W-1:0]   i_datain_q, i_datain_d;
    logic [DATA_W-1:0]   d_datain_q, d_datain_d;

    logic [DATA_W-1:0]   imem [DEPTH];
    logic [DATA_W-1:0]   dmem [DEPTH];

    logic                ready_c;
    logic                host_wr;
    logic [DATA_W-1:0]   host_word;
    logic                cpu_wr_ok;
    logic                imem_we;
    logic                dmem_we;
    logic [ADDR_W-1:0]   dmem_waddr;
    logic [DATA_W-1:0]   dmem_wdata;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        tgt_d   = tgt_q;
        ready_c = 1'b0;
        host_wr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // a run request wins over a header byte in the same cycle
                ready_c = !host_go;
                if (host_go) begin
                    state_d = ST_START;
                end else if (host_valid) begin
                    ptr_d   = ADDR_W'(host_data);
                    tgt_d   = host_sel;
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                ready_c = 1'b1;
                if (host_valid) begin
                    cnt_d   = host_data;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                ready_c = 1'b1;
                if (host_valid) begin
                    hi_d    = host_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                ready_c = 1'b1;
                if (host_valid) begin
                    host_wr = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    // count 0 wraps to 255 here, which yields 256 words in total
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? ST_IDLE : ST_HI;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (host_stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            tgt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            tgt_q   <= tgt_d;
        end
    end

    // Host writes happen only in LO and CPU writes only in START/RUN, so the
    // dmem write port never has to arbitrate.
    always_comb begin
        host_word  = DATA_W'({hi_q, host_data});
        cpu_wr_ok  = (state_q == ST_START) || (state_q == ST_RUN);
        imem_we    = host_wr && !tgt_q;
        dmem_we    = (host_wr && tgt_q) || (d_we && cpu_wr_ok);
        dmem_waddr = host_wr ? ptr_q : d_addr;
        dmem_wdata = host_wr ? host_word : d_dataout;
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (imem_we) begin
            imem[ptr_q] <= host_word;
        end
        if (dmem_we) begin
            dmem[dmem_waddr] <= dmem_wdata;
        end
    end

    // Registered reads sample the array before this edge's write, giving
    // old-data behaviour on a read-during-write.
    always_comb begin
        i_datain_d = imem[i_addr];
        d_datain_d = dmem[d_addr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_datain_q <= '0;
            d_datain_q <= '0;
        end else begin
            i_datain_q <= i_datain_d;
            d_datain_q <= d_datain_d;
        end
    end

    // Reset gates host_ready directly so it is low for the whole reset period.
    assign host_ready = reset && ready_c;
    assign busy       = (state_q != ST_IDLE);
    assign start      = (state_q == ST_START);
    assign enable     = (state_q == ST_START) || (state_q == ST_RUN);
    assign i_datain   = i_datain_q;
    assign d_datain   = d_datain_q;

endmodule

// File: tb/tb_pcpu_mem_host.sv
module tb_pcpu_mem_host;

    localparam int KS = 0;   // status {busy,start,enable,host_ready}
    localparam int KI = 1;   // i_datain
    localparam int KD = 2;   // d_datain

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [7:0]  host_data = 8'h00;
    logic        host_sel = 1'b0;
    logic        host_go = 1'b0;
    logic        host_stop = 1'b0;
    logic        busy, start, enable;
    logic [7:0]  i_addr = 8'h00;
    logic [15:0] i_datain;
    logic [7:0]  d_addr = 8'h00;
    logic [15:0] d_dataout = 16'h0000;
    logic        d_we = 1'b0;
    logic [15:0] d_datain;

    pcpu_mem_host #(.ADDR_W(8), .DATA_W(16)) dut (
        .clock(clock), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_data(host_data), .host_sel(host_sel),
        .host_go(host_go), .host_stop(host_stop),
        .busy(busy), .start(start), .enable(enable),
        .i_addr(i_addr), .i_datain(i_datain),
        .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we),
        .d_datain(d_datain)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        longint      due;
        logic [15:0] exp;
        logic [7:0]  addr;
    } chk_t;

    chk_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // reference model: plain memory images with written-flags
    logic [15:0] imem_m [256];
    logic [15:0] dmem_m [256];
    bit          imem_v [256];
    bit          dmem_v [256];
    logic [15:0] wq[$];

    function automatic void push_chk(input int kind, input logic [15:0] exp,
                                     input logic [7:0] addr, input longint dly);
        chk_t c;
        c.kind = kind;
        c.due  = longint'($time) + dly;
        c.exp  = exp;
        c.addr = addr;
        sb_q.push_back(c);
    endfunction

    function automatic void push_stat(input logic [3:0] exp);
        push_chk(KS, {12'h000, exp}, 8'h00, 1);
    endfunction

    // monitor: compares every queued expectation once its due time arrives
    initial begin
        forever begin
            @(posedge clock or negedge clock);
            #1;
            for (int i = 0; i < sb_q.size(); ) begin
                if (sb_q[i].due <= longint'($time)) begin
                    logic [15:0] act;
                    string       nm;
                    case (sb_q[i].kind)
                        KS: begin act = {12'h000, busy, start, enable, host_ready}; nm = "status"; end
                        KI: begin act = i_datain; nm = "i_datain"; end
                        default: begin act = d_datain; nm = "d_datain"; end
                    endcase
                    n_tests++;
                    if (act !== sb_q[i].exp) begin
                        n_fail++;
                        $display("FAIL %s addr=%02h actual=%04h required=%04h at %0t",
                                 nm, sb_q[i].addr, act, sb_q[i].exp, $time);
                    end
                    sb_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic sel, input logic exp_busy);
        @(negedge clock);
        host_valid = 1'b1;
        host_data  = b;
        host_sel   = sel;
        push_stat({exp_busy, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic maybe_gap();
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clock);
            host_valid = 1'b0;
            host_data  = 8'($urandom);
            push_stat(4'b1001);
        end
    endtask

    // sends a whole frame from wq and updates the model from the frame rules
    task automatic host_load(input logic sel, input logic [7:0] ptr,
                             input logic [7:0] cnt, input bit gaps);
        int n;
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        send_byte(ptr, sel, 1'b0);
        if (gaps) maybe_gap();
        send_byte(cnt, sel, 1'b1);
        for (int k = 0; k < n; k++) begin
            int a;
            if (gaps) maybe_gap();
            send_byte(wq[k][15:8], sel, 1'b1);
            if (gaps) maybe_gap();
            send_byte(wq[k][7:0], sel, 1'b1);
            a = (int'(ptr) + k) % 256;
            if (sel) begin dmem_m[a] = wq[k]; dmem_v[a] = 1'b1; end
            else     begin imem_m[a] = wq[k]; imem_v[a] = 1'b1; end
        end
        @(negedge clock);
        host_valid = 1'b0;
        push_stat(4'b0001);
    endtask

    task automatic rd_i(input logic [7:0] a);
        @(negedge clock);
        i_addr = a;
        if (imem_v[a]) push_chk(KI, imem_m[a], a, 6);
    endtask

    task automatic rd_d(input logic [7:0] a);
        @(negedge clock);
        d_addr = a;
        if (dmem_v[a]) push_chk(KD, dmem_m[a], a, 6);
    endtask

    task automatic read_back(input logic sel, input logic [7:0] ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (sel) rd_d(8'(int'(ptr) + k));
            else     rd_i(8'(int'(ptr) + k));
        end
    endtask

    initial begin
        logic [7:0]  addrs[$];
        for (int i = 0; i < 256; i++) begin
            imem_v[i] = 1'b0;
            dmem_v[i] = 1'b0;
        end

        // reset asserted
        #2 reset = 1'b0;
        @(negedge clock);
        push_stat(4'b0000);
        push_chk(KI, 16'h0000, 8'h00, 1);
        push_chk(KD, 16'h0000, 8'h00, 1);
        @(negedge clock);
        reset = 1'b1;
        push_stat(4'b0001);
        push_chk(KI, 16'h0000, 8'h00, 1);
        push_chk(KD, 16'h0000, 8'h00, 1);
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy after reset actual=%b required=0 at %0t", busy, $time);
        end

        // directed imem load
        wq = '{16'h1234, 16'hABCD};
        host_load(1'b0, 8'h10, 8'h02, 1'b0);
        rd_i(8'h11);
        rd_i(8'h10);

        // dmem load wrapping past 0xFF
        wq = '{16'h0001, 16'h0002};
        host_load(1'b1, 8'hFF, 8'h02, 1'b1);
        rd_d(8'hFF);
        rd_d(8'h00);

        // known dmem contents around 0x05 for the CPU write checks
        wq = '{16'h4444, 16'h5555, 16'h6666};
        host_load(1'b1, 8'h04, 8'h03, 1'b1);
        read_back(1'b1, 8'h04, 3);

        // randomized loads with random gaps
        for (int r = 0; r < 6; r++) begin
            logic       sel;
            logic [7:0] p, c;
            sel = 1'($urandom);
            p   = 8'($urandom_range(16, 200));
            c   = 8'($urandom_range(1, 6));
            wq.delete();
            for (int k = 0; k < int'(c); k++) wq.push_back(16'($urandom));
            host_load(sel, p, c, 1'b1);
            read_back(sel, p, int'(c));
        end

        // run request together with a host byte: go wins
        @(negedge clock);
        host_go = 1'b1; host_valid = 1'b1; host_data = 8'h55; host_sel = 1'b0;
        push_stat(4'b0000);
        #1;
        n_tests++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL host_ready with host_go actual=%b required=0 at %0t", host_ready, $time);
        end
        @(negedge clock);
        host_go = 1'b0; host_valid = 1'b0;
        push_stat(4'b1110);
        @(negedge clock);
        host_valid = 1'b1; host_data = 8'h77;
        push_stat(4'b1010);
        @(negedge clock);
        host_valid = 1'b0;
        d_we = 1'b1; d_addr = 8'h05; d_dataout = 16'h000B;
        push_chk(KD, dmem_m[5], 8'h05, 6);          // old data on read-during-write
        push_stat(4'b1010);
        dmem_m[5] = 16'h000B;
        @(negedge clock);
        d_we = 1'b0;
        push_chk(KD, 16'h000B, 8'h05, 6);
        push_stat(4'b1010);

        // random CPU writes while running, then read back
        for (int r = 0; r < 8; r++) begin
            logic [7:0]  a;
            logic [15:0] v;
            a = 8'($urandom_range(8, 255));
            v = 16'($urandom);
            @(negedge clock);
            d_we = 1'b1; d_addr = a; d_dataout = v;
            if (dmem_v[a]) push_chk(KD, dmem_m[a], a, 6);
            push_stat(4'b1010);
            dmem_m[a] = v; dmem_v[a] = 1'b1;
            addrs.push_back(a);
        end
        @(negedge clock);
        d_we = 1'b0;
        foreach (addrs[k]) rd_d(addrs[k]);
        rd_i(8'h10);

        // stop
        @(negedge clock);
        host_stop = 1'b1;
        push_stat(4'b1010);
        @(negedge clock);
        host_stop = 1'b0;
        push_stat(4'b0001);

        // count 0 means 256 words
        wq.delete();
        for (int k = 0; k < 256; k++) wq.push_back(16'($urandom));
        host_load(1'b0, 8'h00, 8'h00, 1'b0);
        read_back(1'b0, 8'h00, 256);

        // reset mid-run drops enable without waiting for an edge
        @(negedge clock);
        host_go = 1'b1;
        push_stat(4'b0000);
        @(negedge clock);
        host_go = 1'b0;
        push_stat(4'b1110);
        @(negedge clock);
        push_stat(4'b1010);
        @(negedge clock);
        reset = 1'b0;
        push_stat(4'b0000);
        push_chk(KI, 16'h0000, 8'h00, 1);
        push_chk(KD, 16'h0000, 8'h00, 1);
        #1;
        n_tests++;
        if (enable !== 1'b0) begin
            n_fail++;
            $display("FAIL enable during reset actual=%b required=0 at %0t", enable, $time);
        end
        @(negedge clock);
        reset = 1'b1;
        push_stat(4'b0001);

        // reset mid-load after the high byte: word at 0x05 must survive
        send_byte(8'h05, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(8'hEE, 1'b1, 1'b1);
        @(negedge clock);
        host_valid = 1'b0;
        reset = 1'b0;
        push_stat(4'b0000);
        @(negedge clock);
        reset = 1'b1;
        push_stat(4'b0001);

        // CPU writes in IDLE are ignored
        for (int r = 0; r < 2; r++) begin
            @(negedge clock);
            d_we = 1'b1; d_addr = 8'h05; d_dataout = 16'hFFFF;
            push_chk(KD, dmem_m[5], 8'h05, 6);
            push_stat(4'b0001);
        end
        @(negedge clock);
        d_we = 1'b0;
        rd_d(8'h05);
        rd_d(8'h04);

        repeat (3) @(negedge clock);
        #3;
        while (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unchecked kind=%0d addr=%02h required=%04h",
                     sb_q[0].kind, sb_q[0].addr, sb_q[0].exp);
            sb_q.delete(0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
